// File: rtl/psum_collector.sv
// Receive-side partial-sum collector: sums NUM_ACC psums per output value,
// streams each value with its index, and counts zero-gated psums.
module psum_collector #(
   parameter int PSUM_W  = 32,
   parameter int NUM_ACC = 3,
   parameter int NUM_OUT = 16,
   parameter int IDX_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PSUM_W-1:0] in_psum,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PSUM_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic              busy,
   output logic              done,
   output logic [15:0]       zero_count
);

   localparam int CNT_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ACC - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [PSUM_W-1:0] acc;
   logic [CNT_W-1:0]  acc_cnt;
   logic [IDX_W-1:0]  out_idx;
   logic [15:0]       zero_cnt;
   logic              in_fire;
   logic              out_fire;

   // Unsigned add evaluated one bit wider; a carry clamps to all-ones.
   function automatic logic [PSUM_W-1:0] sat_add(input logic [PSUM_W-1:0] a,
                                                 input logic [PSUM_W-1:0] b);
      logic [PSUM_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[PSUM_W] ? {PSUM_W{1'b1}} : sum[PSUM_W-1:0];
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign in_fire  = (state == ACCUM) && in_valid;
   assign out_fire = (state == EMIT) && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACCUM;
         ACCUM:   if (in_fire && (acc_cnt == LAST_CNT)) state_nxt = EMIT;
         EMIT:    if (out_fire) state_nxt = (out_idx == LAST_IDX) ? DONE : ACCUM;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc      <= '0;
         acc_cnt  <= '0;
         out_idx  <= '0;
         zero_cnt <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            acc_cnt  <= '0;
            out_idx  <= '0;
            zero_cnt <= '0;
         end
         if (in_fire) begin
            acc     <= (acc_cnt == '0) ? in_psum : sat_add(acc, in_psum);
            acc_cnt <= acc_cnt + 1'b1;
            if (in_psum == '0) zero_cnt <= sat_inc(zero_cnt);
         end
         // The index stays on the last value through DONE and back to IDLE.
         if (out_fire && (out_idx != LAST_IDX)) begin
            out_idx <= out_idx + 1'b1;
            acc_cnt <= '0;
         end
      end
   end

   assign in_ready   = (state == ACCUM);
   assign out_valid  = (state == EMIT);
   assign out_data   = acc;
   assign out_index  = out_idx;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign zero_count = zero_cnt;

endmodule
